// File: rtl/fc_acc_buf_pkg.sv
// Shared constants, lane types and helpers for the FC accumulate buffer.
// GLOBAL_PARAM holds datapath-wide constants; fc_acc_buf_pkg holds block-local types.
package GLOBAL_PARAM;

    localparam int BATCH = 4;
    localparam int FC_ACC_DATA_W = 16;

    typedef logic signed [FC_ACC_DATA_W-1:0] fc_acc_lane_t;

    // Saturating signed add at the global lane width.
    function automatic fc_acc_lane_t fc_acc_sat_add(
        input fc_acc_lane_t a,
        input fc_acc_lane_t b
    );
        fc_acc_lane_t s;
        s = a + b;
        if ((a[FC_ACC_DATA_W-1] == b[FC_ACC_DATA_W-1]) &&
            (s[FC_ACC_DATA_W-1] != a[FC_ACC_DATA_W-1])) begin
            s = a[FC_ACC_DATA_W-1]
              ? {1'b1, {(FC_ACC_DATA_W-1){1'b0}}}
              : {1'b0, {(FC_ACC_DATA_W-1){1'b1}}};
        end
        return s;
    endfunction

endpackage

package fc_acc_buf_pkg;

    localparam int FC_ACC_ADDR_W = 8;

    // Source of the "old" row seen by the S1 modify step.
    typedef enum logic [1:0] {
        FWD_RAM = 2'd0,
        FWD_S2  = 2'd1,
        FWD_S3  = 2'd2
    } fc_fwd_sel_e;

endpackage

// File: rtl/fc_acc_buf_if.sv
// Accumulate-stream and drain-port bundle of the FC accumulate buffer.
// master: address generator / PE array / layer controller; slave: fc_acc_buf.
interface fc_acc_buf_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    localparam int LANES = GLOBAL_PARAM::BATCH;

    logic                      abuf_valid;
    logic [ADDR_W-1:0]         abuf_addr;
    logic [LANES-1:0]          abuf_acc_en;
    logic                      abuf_acc_new;
    logic [LANES*DATA_W-1:0]   abuf_data;
    logic                      busy;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [LANES*DATA_W-1:0]   rd_data;

    modport master (
        output abuf_valid, abuf_addr, abuf_acc_en,
        output abuf_acc_new, abuf_data,
        output rd_en, rd_addr,
        input  busy, rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  abuf_valid, abuf_addr, abuf_acc_en,
        input  abuf_acc_new, abuf_data,
        input  rd_en, rd_addr,
        output busy, rd_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/fc_acc_ram.sv
// Row memory: 1R1W, synchronous read (1-cycle latency), read-first on collision.
// Ports: clk, re/raddr/rdata read port, we/waddr/wdata write port. Not reset.
module fc_acc_ram #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 64
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Both in one block: the read samples mem before the write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fc_acc_buf.sv
// FC accumulate buffer: pipelined per-lane read-modify-write with S2/S3 forwarding.
// Ports: clk, rst (sync, active-high), bus (fc_acc_buf_if.slave). Macro: FC_ACC_SAT_EN.
module fc_acc_buf
    import GLOBAL_PARAM::*;
    import fc_acc_buf_pkg::*;
#(
    parameter int ADDR_W = FC_ACC_ADDR_W,
    parameter int DATA_W = FC_ACC_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    fc_acc_buf_if.slave    bus
);

    localparam int ROW_W = BATCH * DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BATCH-1:0]  en;
        logic              acc_new;
        logic [ROW_W-1:0]  data;
    } req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  row;
    } wr_t;

    logic        s1_valid;
    logic        s2_valid;
    logic        s3_valid;
    req_t        s1;
    wr_t         s2;
    wr_t         s3;

    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [ROW_W-1:0]  ram_dout;
    logic              ram_we;

    fc_fwd_sel_e       fwd_sel;
    logic [ROW_W-1:0]  old_row;
    logic [ROW_W-1:0]  s1_row;

    logic              busy;
    logic              rd_ready;
    logic              rd_fire;
    logic              rd_valid;
    logic [ROW_W-1:0]  rd_hold;

    function automatic logic [DATA_W-1:0] lane_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] s;
        s = a + b;
`ifdef FC_ACC_SAT_EN
        // Same-sign operands with a sign flip in the sum overflowed.
        if ((a[DATA_W-1] == b[DATA_W-1]) &&
            (s[DATA_W-1] != a[DATA_W-1])) begin
            s = a[DATA_W-1]
              ? {1'b1, {(DATA_W-1){1'b0}}}
              : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    assign busy     = s1_valid | s2_valid;
    assign rd_ready = ~bus.abuf_valid & ~busy;
    assign rd_fire  = bus.rd_en & rd_ready;

    // Accumulate reads win the port; a drain only fires when idle anyway.
    assign ram_re    = bus.abuf_valid | rd_fire;
    assign ram_raddr = bus.abuf_valid ? bus.abuf_addr : bus.rd_addr;
    assign ram_we    = s2_valid & ~rst;

    fc_acc_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (ROW_W)
    ) u_ram (
        .clk    (clk),
        .re     (ram_re),
        .raddr  (ram_raddr),
        .rdata  (ram_dout),
        .we     (ram_we),
        .waddr  (s2.addr),
        .wdata  (s2.row)
    );

    // S2 holds the newest result, so it beats S3 on a double hit.
    always_comb begin
        fwd_sel = FWD_RAM;
        if (s2_valid && (s2.addr == s1.addr)) begin
            fwd_sel = FWD_S2;
        end else if (s3_valid && (s3.addr == s1.addr)) begin
            fwd_sel = FWD_S3;
        end
    end

    always_comb begin
        unique case (fwd_sel)
            FWD_S2:  old_row = s2.row;
            FWD_S3:  old_row = s3.row;
            default: old_row = ram_dout;
        endcase
    end

    always_comb begin
        s1_row = old_row;
        for (int i = 0; i < BATCH; i++) begin
            if (s1.en[i]) begin
                if (s1.acc_new) begin
                    s1_row[i*DATA_W +: DATA_W] =
                        s1.data[i*DATA_W +: DATA_W];
                end else begin
                    s1_row[i*DATA_W +: DATA_W] =
                        lane_add(old_row[i*DATA_W +: DATA_W],
                                 s1.data[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= bus.abuf_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Payloads need no reset; the valid bits above qualify them.
    always_ff @(posedge clk) begin
        if (bus.abuf_valid) begin
            s1.addr    <= bus.abuf_addr;
            s1.en      <= bus.abuf_acc_en;
            s1.acc_new <= bus.abuf_acc_new;
            s1.data    <= bus.abuf_data;
        end
        if (s1_valid) begin
            s2.addr <= s1.addr;
            s2.row  <= s1_row;
        end
        if (s2_valid) begin
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_valid) begin
                rd_hold <= ram_dout;
            end
        end
    end

    // RAM dout is live during rd_valid; afterwards the captured copy holds.
    assign bus.rd_data  = rd_valid ? ram_dout : rd_hold;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_ready = rd_ready;
    assign bus.busy     = busy;

endmodule

// File: doc/fc_acc_buf.md
# fc_acc_buf

Accumulate buffer for the fully-connected datapath, directly downstream of the FC address generator. It consumes the generator's `abuf_addr` / `abuf_acc_en` / `abuf_acc_new` stream together with per-lane products from the PE array, and performs a pipelined read-modify-write into an on-chip row memory, with hazard forwarding. A separate read port lets the layer controller drain results once the pipeline is idle.

## Interface
- `ADDR_W`, default 8: row address width; depth is 2^ADDR_W rows.
- `DATA_W`, default 16: per-lane accumulator width, signed two's complement.
- Lane count is `BATCH` from `GLOBAL_PARAM`; a row is `BATCH*DATA_W` bits, lane i at bits `[i*DATA_W +: DATA_W]`.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `abuf_valid`  in  1  accumulate request valid this cycle; no backpressure, every valid cycle is accepted.
- `abuf_addr`  in  ADDR_W  target row.
- `abuf_acc_en`  in  BATCH  per-lane enable; disabled lanes keep their stored value.
- `abuf_acc_new`  in  1  enabled lanes load `abuf_data` instead of adding to it.
- `abuf_data`  in  BATCH*DATA_W  per-lane addend.
- `busy`  out  1  any accumulate pipeline stage holds a valid request.
- `rd_en`  in  1  drain read request; honoured only when `rd_ready` is high.
- `rd_addr`  in  ADDR_W  drain row.
- `rd_ready`  out  1  `~abuf_valid & ~busy`.
- `rd_valid`  out  1  `rd_data` valid; asserted one cycle after an honoured `rd_en`.
- `rd_data`  out  BATCH*DATA_W  drained row.

## Operation
- Row memory: one synchronous read port (1-cycle latency) and one write port, read-first on a same-address collision. RAM contents are not reset; software initialises rows with `abuf_acc_new`.
- Read-port mux: an accumulate read takes priority. `rd_en` with `rd_ready` low is dropped, with no queueing.
- Stage S0 (cycle t): `abuf_valid` issues a RAM read at `abuf_addr`. The request fields are captured into S1.
- Stage S1 (t+1): `old` is selected in priority order:
  - S2 row, if S2 is valid and S2.addr equals S1.addr;
  - otherwise the S3 row, if S3 is valid and S3.addr equals S1.addr;
  - otherwise RAM dout.
- Per-lane S1 result:
  - lane enabled and `acc_new` set: `data`;
  - lane enabled and `acc_new` clear: `old + data`;
  - lane disabled: `old`.
  The full row result is registered into S2.
- Stage S2 (t+2): the full row is written to RAM at S2.addr. S2 is copied into S3, a forward-only register that covers the read-first collision of a request issued in the same cycle.
- Arithmetic: `DATA_W`-bit signed add. Wrapping vs saturating is selected by macro (see Configuration).
- `busy = S1.valid | S2.valid`. S3 does not count toward `busy`, because its write has already completed.

## Timing
- Reset values: `busy` 0, `rd_ready` 1 (given `abuf_valid` low), `rd_valid` 0, `rd_data` 0. S1, S2 and S3 valid bits are cleared.
- Accumulate latency: a request at cycle t is visible in RAM from a read issued at t+3 onward. Back-to-back requests to the same row at distances 1 and 2 are forwarded, so the results are exact at full throughput (1 request/cycle).
- Drain: `rd_en & rd_ready` at cycle t gives `rd_data` at t+1 with `rd_valid` high for exactly one cycle. `rd_data` holds its value when `rd_valid` is low.
- Reset mid-operation: in-flight S1 and S2 requests are discarded, so no RAM write occurs after the reset cycle. RAM keeps whatever was written before.
- `abuf_acc_en` all zeros: the row is rewritten unchanged, which is legal.
- Address wrap: none. Addresses are used modulo 2^ADDR_W.

## Configuration
- `FC_ACC_SAT_EN` defined: per-lane add saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- `FC_ACC_SAT_EN` undefined: two's-complement wraparound. The `acc_new` load path is unaffected in both cases.

## Structure
- `GLOBAL_PARAM` gains an `FC_ACC_DATA_W` constant (default 16) and a lane typedef `fc_acc_lane_t` (signed, `FC_ACC_DATA_W` bits). The saturating-add function also lives there.
- Sub-module `fc_acc_ram`: 1R1W, synchronous read, read-first, parameterised by depth and width. It is the only memory inference point.

## Test plan
- Load then add: `acc_new`=1, `en`=all, data=5 to row 3; later `acc_new`=0, data=7 to row 3; drain row 3 -> every lane reads 12.
- Distance-1/2 hazard: row 9 is loaded with 1. The next three consecutive cycles add 2, 3, 4 to row 9 -> drain reads 10 on all lanes.
- Lane mask: row 4 all lanes = 100; add 1 with `en`=`'b0101` (BATCH≥4) -> lanes 0 and 2 read 101, lanes 1 and 3 read 100.
- Overflow at DATA_W=16: lane = 32767, add 1 -> reads 32767 with `FC_ACC_SAT_EN`, reads -32768 without it.
- Drain gating: `rd_en` asserted while `abuf_valid` is high or for 2 cycles after -> `rd_ready` low, no `rd_valid`. Once idle, `rd_en` -> `rd_valid` exactly 1 cycle later.
- Reset mid-stream: `rst` asserted the cycle after an add to row 2 -> `busy`=0 next cycle, and row 2 drains to its pre-add value.
